isq_select_ctrl: RTL and testbench



---
 rtl/isq_select_ctrl_pkg.sv | 25 ++
 rtl/isq_age_picker.sv | 17 +
 rtl/isq_select_ctrl.sv | 119 +++++++++++
 tb/tb_isq_select_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isq_select_ctrl_pkg.sv
// Shared ISU issue-queue types: entry layout, default widths and the condition merge rule.
package isq_select_ctrl_pkg;

  localparam int ISQ_DEPTH           = 8;
  localparam int ISQ_DATA_WIDTH      = 248;
  localparam int ISQ_CONDITION_WIDTH = 2;
  localparam int ISQ_INDEX_WIDTH     = 4;

  typedef struct packed {
    logic                           valid;
    logic [ISQ_DATA_WIDTH-1:0]      data;
    logic [ISQ_CONDITION_WIDTH-1:0] condition;
    logic [ISQ_INDEX_WIDTH-1:0]     index;
  } isq_entry_t;

  // Masked bits take the broadcast value, the rest keep their current value.
  function automatic logic [ISQ_CONDITION_WIDTH-1:0] cond_merge(
    input logic [ISQ_CONDITION_WIDTH-1:0] cond,
    input logic [ISQ_CONDITION_WIDTH-1:0] mask,
    input logic [ISQ_CONDITION_WIDTH-1:0] value
  );
    return (value & mask) | (cond & ~mask);
  endfunction

endpackage

// File: rtl/isq_age_picker.sv
// Oldest-ready picker: grants the ready entry that has no older ready entry.
module isq_age_picker #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            ready_i,
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        any_grant_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_grant
    assign grant_o[i] = ready_i[i] & ~(|(ready_i & older_i[i]));
  end

  assign any_grant_o = |ready_i;

endmodule

// File: rtl/isq_select_ctrl.sv
// Issue-queue bank scheduler: allocate on enqueue, tag wakeup, oldest-ready select, flush.
// Handshakes: a transfer happens at a rising edge where valid && ready; enq_ready comes from
// registered occupancy only and iss_valid never depends on iss_ready.
module isq_select_ctrl
  import isq_select_ctrl_pkg::*;
#(
  parameter int DEPTH           = ISQ_DEPTH,
  parameter int DATA_WIDTH      = ISQ_DATA_WIDTH,
  parameter int CONDITION_WIDTH = ISQ_CONDITION_WIDTH,
  parameter int INDEX_WIDTH     = ISQ_INDEX_WIDTH,
  parameter int OCC_WIDTH       = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DATA_WIDTH-1:0]      enq_data,
  input  logic [CONDITION_WIDTH-1:0] enq_condition,
  input  logic [INDEX_WIDTH-1:0]     enq_index,
  input  logic                       wk_valid,
  input  logic [INDEX_WIDTH-1:0]     wk_index,
  input  logic [CONDITION_WIDTH-1:0] wk_mask,
  input  logic [CONDITION_WIDTH-1:0] wk_value,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [DATA_WIDTH-1:0]      iss_data,
  output logic [INDEX_WIDTH-1:0]     iss_index,
  input  logic                       flush,
  output logic [OCC_WIDTH-1:0]       occupancy
);

  localparam logic [OCC_WIDTH-1:0] FULL_OCC = OCC_WIDTH'(DEPTH);

  isq_entry_t                    ent_q [DEPTH];
  isq_entry_t                    ent_d [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0]   older_q, older_d;
  logic [OCC_WIDTH-1:0]          occ_q, occ_d;
  logic [DEPTH-1:0]              valid_vec, ready_vec, alloc_oh, grant, lower_valid;
  logic                          enq_fire, iss_fire, any_grant;
  logic [CONDITION_WIDTH-1:0]    enq_cond;

  // Lowest-set-bit encoder over the invalid entries picks the allocation target.
  assign lower_valid[0] = 1'b1;
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign valid_vec[i] = ent_q[i].valid;
    assign ready_vec[i] = ent_q[i].valid & (&ent_q[i].condition);
    assign alloc_oh[i]  = ~ent_q[i].valid & lower_valid[i];
    if (i < DEPTH - 1) begin : g_chain
      assign lower_valid[i+1] = lower_valid[i] & ent_q[i].valid;
    end
  end

  isq_age_picker #(.DEPTH(DEPTH)) u_picker (
    .ready_i     (ready_vec),
    .older_i     (older_q),
    .grant_o     (grant),
    .any_grant_o (any_grant)
  );

  assign enq_ready = (occ_q != FULL_OCC);
  assign iss_valid = any_grant;
  assign occupancy = occ_q;
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign iss_fire  = iss_valid & iss_ready & ~flush;
  assign enq_cond  = (wk_valid && (wk_index == enq_index)) ?
                     cond_merge(enq_condition, wk_mask, wk_value) : enq_condition;

  always_comb begin
    iss_data  = '0;
    iss_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_data  = iss_data | ent_q[i].data;
        iss_index = iss_index | ent_q[i].index;
      end
    end
  end

  always_comb begin
    ent_d   = ent_q;
    older_d = older_q;
    occ_d   = flush ? '0 : occ_q + OCC_WIDTH'(enq_fire) - OCC_WIDTH'(iss_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        ent_d[i].valid     = 1'b0;
        ent_d[i].condition = '0;
      end else if (iss_fire && grant[i]) begin
        ent_d[i] = '0;
      end else if (enq_fire && alloc_oh[i]) begin
        ent_d[i].valid     = 1'b1;
        ent_d[i].data      = enq_data;
        ent_d[i].condition = enq_cond;
        ent_d[i].index     = enq_index;
      end else if (ent_q[i].valid && wk_valid && (ent_q[i].index == wk_index)) begin
        ent_d[i].condition = cond_merge(ent_q[i].condition, wk_mask, wk_value);
      end
    end
    // New entry is younger than everything valid now; nobody is younger than it.
    for (int k = 0; k < DEPTH; k++) begin
      if (enq_fire && alloc_oh[k]) begin
        older_d[k] = valid_vec;
        for (int j = 0; j < DEPTH; j++) older_d[j][k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      older_q <= older_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_isq_select_ctrl.sv
// Bench for isq_select_ctrl: directed scenarios plus random traffic against a sequence-number model.
module tb_isq_select_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 248;
  localparam int CW    = 2;
  localparam int IW    = 4;
  localparam int OW    = 4;

  logic          clock, reset_n;
  logic          enq_valid, enq_ready;
  logic [DW-1:0] enq_data;
  logic [CW-1:0] enq_condition;
  logic [IW-1:0] enq_index;
  logic          wk_valid;
  logic [IW-1:0] wk_index;
  logic [CW-1:0] wk_mask, wk_value;
  logic          iss_valid, iss_ready;
  logic [DW-1:0] iss_data;
  logic [IW-1:0] iss_index;
  logic          flush;
  logic [OW-1:0] occupancy;

  isq_select_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_condition(enq_condition), .enq_index(enq_index),
    .wk_valid(wk_valid), .wk_index(wk_index), .wk_mask(wk_mask), .wk_value(wk_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data), .iss_index(iss_index),
    .flush(flush), .occupancy(occupancy)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // scoreboard and model state
  int n_cmp = 0;
  int n_err = 0;
  logic [DW+IW-1:0] exp_q[$];

  logic          m_valid [DEPTH];
  logic [DW-1:0] m_data  [DEPTH];
  logic [CW-1:0] m_cond  [DEPTH];
  logic [IW-1:0] m_idx   [DEPTH];
  int            m_seq   [DEPTH];
  int            m_occ;
  int            seq_ctr;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = '0;
    for (int w = 0; w < 8; w++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_data[i] = '0; m_cond[i] = '0; m_idx[i] = '0; m_seq[i] = 0;
    end
    m_occ   = 0;
    seq_ctr = 0;
    exp_q.delete();
  endtask

  // Oldest ready entry = smallest enqueue sequence number among valid, all-ones entries.
  function automatic int model_pick();
    int g = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && (m_cond[i] == {CW{1'b1}}) && (g < 0 || m_seq[i] < m_seq[g])) g = i;
    return g;
  endfunction

  task automatic model_step(input logic ev, input logic [CW-1:0] ec, input logic [IW-1:0] ei,
                            input logic [DW-1:0] ed, input logic wv, input logic [IW-1:0] wi,
                            input logic [CW-1:0] wm, input logic [CW-1:0] wval,
                            input logic ir, input logic fl);
    int  g, slot;
    bit  efire, ifire;
    logic [CW-1:0] c;
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_cond[i] = '0; end
      m_occ = 0;
      return;
    end
    g     = model_pick();
    efire = ev && (m_occ != DEPTH);
    ifire = (g >= 0) && ir;
    slot  = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && slot < 0) slot = i;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && wv && m_idx[i] == wi) m_cond[i] = (wval & wm) | (m_cond[i] & ~wm);
    if (ifire) begin
      exp_q.push_back({m_data[g], m_idx[g]});
      m_valid[g] = 1'b0; m_data[g] = '0; m_cond[g] = '0; m_idx[g] = '0;
    end
    if (efire && slot >= 0) begin
      c = ec;
      if (wv && wi == ei) c = (wval & wm) | (c & ~wm);
      m_valid[slot] = 1'b1; m_data[slot] = ed; m_cond[slot] = c; m_idx[slot] = ei;
      m_seq[slot] = seq_ctr++;
    end
    m_occ = m_occ + int'(efire) - int'(ifire);
  endtask

  task automatic check_outputs();
    int g = model_pick();
    check("iss_valid", iss_valid, g >= 0);
    check("iss_index", iss_index, (g >= 0) ? m_idx[g] : '0);
    check("iss_data",  iss_data,  (g >= 0) ? m_data[g] : '0);
    check("enq_ready", enq_ready, m_occ != DEPTH);
    check("occupancy", occupancy, m_occ);
  endtask

  // driver: called at a falling edge, applies inputs for one cycle, checks at the next falling edge
  task automatic drive_cycle(input logic ev, input logic [CW-1:0] ec, input logic [IW-1:0] ei,
                             input logic wv, input logic [IW-1:0] wi, input logic [CW-1:0] wm,
                             input logic [CW-1:0] wval, input logic ir, input logic fl);
    logic [DW+IW-1:0] e;
    enq_valid = ev; enq_condition = ec; enq_index = ei; enq_data = rand_data();
    wk_valid = wv; wk_index = wi; wk_mask = wm; wk_value = wval;
    iss_ready = ir; flush = fl;
    #1;
    model_step(ev, ec, ei, enq_data, wv, wi, wm, wval, ir, fl);
    if (iss_valid && iss_ready && !flush) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_sb", {iss_data, iss_index}, e);
      end else begin
        check("issue_sb_extra", 1'b1, 1'b0);
      end
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle_inputs();
    enq_valid = 0; enq_data = '0; enq_condition = '0; enq_index = '0;
    wk_valid = 0; wk_index = '0; wk_mask = '0; wk_value = '0;
    iss_ready = 0; flush = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_occ"},   occupancy, 0);
    check({tag, "_erdy"},  enq_ready, 1);
    check({tag, "_ivld"},  iss_valid, 0);
    check({tag, "_idata"}, iss_data,  0);
    check({tag, "_iidx"},  iss_index, 0);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;

    // single ready enqueue visible one cycle later
    drive_cycle(1, 2'b11, 4'd3, 0, 0, 0, 0, 0, 0);
    check("t1_iss_index", iss_index, 3);
    check("t1_occ", occupancy, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // age order beats wake order
    drive_cycle(1, 2'b00, 4'd1, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 2'b00, 4'd2, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 2'b00, 4'd5, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 4'd5, 2'b11, 2'b11, 0, 0);
    check("wake5_idx", iss_index, 5);
    drive_cycle(0, 0, 0, 1, 4'd1, 2'b11, 2'b11, 0, 0);
    check("age_pick_idx", iss_index, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("second_idx", iss_index, 5);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("tag2_left_occ", occupancy, 1);
    check("tag2_not_ready", iss_valid, 0);

    // wakeup bypass on the enqueue cycle
    drive_cycle(1, 2'b01, 4'd4, 1, 4'd4, 2'b10, 2'b10, 0, 0);
    check("bypass_valid", iss_valid, 1);
    check("bypass_idx", iss_index, 4);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // fill, then free one slot with enqueue held
    for (int i = 0; i < DEPTH; i++) drive_cycle(1, 2'b11, IW'(i), 0, 0, 0, 0, 0, 0);
    check("full_enq_ready", enq_ready, 0);
    drive_cycle(1, 2'b00, 4'd9, 0, 0, 0, 0, 1, 0);
    check("freed_enq_ready", enq_ready, 1);
    check("freed_occ", occupancy, 7);
    drive_cycle(1, 2'b00, 4'd9, 0, 0, 0, 0, 0, 0);
    check("refill_occ", occupancy, 8);

    // stable output while stalled, then flush with enqueue
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 2'b11, 4'd6, 0, 0, 0, 0, 1, 1);
    check("flush_occ", occupancy, 0);
    check("flush_ivld", iss_valid, 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      drive_cycle($urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) ? 2'b11 : CW'($urandom()),
                  IW'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 4,
                  IW'($urandom_range(0, 7)),
                  CW'($urandom()), CW'($urandom()),
                  $urandom_range(0, 9) < 5,
                  $urandom_range(0, 49) == 0);
    end

    // asynchronous reset in the middle of a fill
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive_cycle(1, 2'b11, IW'(i + 1), 0, 0, 0, 0, 0, 0);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
    drive_cycle(1, 2'b11, 4'd7, 0, 0, 0, 0, 0, 0);
    check("post_reset_idx", iss_index, 7);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
